// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        EMIT
    } state_t;

    localparam int BLOCK_W      = 512;
    localparam int WORD_W       = 32;
    localparam int LEN_FIELD_W  = 64;
    localparam int BLOCK_WORDS  = BLOCK_W / WORD_W;
    localparam logic [7:0] PAD_MARKER = 8'h80;

    function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Combinational last-word masker: keeps the valid leading bytes, inserts the
// 0x80 marker after them and zeroes the rest; flags when the marker spills over.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        bytes,
    output logic [WORD_W-1:0] padded,
    output logic              spill
);

    logic [2:0] n_valid;

    // A byte count of zero means the whole word is message data.
    assign n_valid = (bytes == 2'd0) ? 3'd4 : {1'b0, bytes};
    assign spill   = (bytes == 2'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            localparam int HI = WORD_W - 1 - 8 * gi;
            assign padded[HI -: 8] = (3'(gi) < n_valid)  ? word[HI -: 8] :
                                     (3'(gi) == n_valid) ? PAD_MARKER    : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/sha256_padder.sv
// FIPS 180-4 padder: packs a 32-bit word stream into 512-bit blocks.
// Define SHA256_PADDER_BSWAP_EN for a little-endian input bus.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    input  logic [1:0]         in_bytes,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [511:0]       blk_data,
    output logic               blk_first,
    output logic               blk_last
);

    state_t                 state_reg, state_next;
    logic [3:0]             idx_reg, idx_next;
    logic [LEN_W-1:0]       len_reg, len_next;
    logic                   first_reg, first_next;
    logic                   last_reg, last_next;
    logic                   extra_reg, extra_next;
    logic                   pend_reg, pend_next;
    logic                   spill_reg, spill_next;
    logic [4:0]             mark_reg, mark_next;
    logic                   ready_en_reg;

    logic [WORD_W-1:0]      data_sw;
    logic [WORD_W-1:0]      pad_data;
    logic                   pad_spill;
    logic [WORD_W-1:0]      wr_word;
    logic [6:0]             add_bits;
    logic [LEN_FIELD_W-1:0] len_field;
    logic                   accept;
    logic                   handshake;

`ifdef SHA256_PADDER_BSWAP_EN
    assign data_sw = bswap32(in_data);
`else
    assign data_sw = in_data;
`endif

    sha256_pad_word u_pad_word (
        .word   (data_sw),
        .bytes  (in_bytes),
        .padded (pad_data),
        .spill  (pad_spill)
    );

    assign in_ready  = (state_reg == FILL) && ready_en_reg;
    assign blk_valid = (state_reg == EMIT);
    assign blk_first = blk_valid && first_reg;
    assign blk_last  = blk_valid && last_reg;
    assign accept    = in_valid && in_ready;
    assign handshake = blk_valid && blk_ready;
    assign wr_word   = in_last ? pad_data : data_sw;
    assign add_bits  = (in_last && in_bytes != 2'd0) ? 7'({in_bytes, 3'b000}) : 7'd32;
    assign len_field = LEN_FIELD_W'(len_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FILL;
            idx_reg      <= '0;
            len_reg      <= '0;
            first_reg    <= 1'b1;
            last_reg     <= 1'b0;
            extra_reg    <= 1'b0;
            pend_reg     <= 1'b0;
            spill_reg    <= 1'b0;
            mark_reg     <= '0;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            len_reg      <= len_next;
            first_reg    <= first_next;
            last_reg     <= last_next;
            extra_reg    <= extra_next;
            pend_reg     <= pend_next;
            spill_reg    <= spill_next;
            mark_reg     <= mark_next;
            ready_en_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        len_next   = len_reg;
        first_next = first_reg;
        last_next  = last_reg;
        extra_next = extra_reg;
        pend_next  = pend_reg;
        spill_next = spill_reg;
        mark_next  = mark_reg;
        case (state_reg)
            FILL: begin
                if (accept) begin
                    idx_next = idx_reg + 4'd1;
                    len_next = len_reg + LEN_W'(add_bits);
                    if (in_last) begin
                        state_next = PAD;
                        spill_next = pad_spill;
                        mark_next  = {1'b0, idx_reg} + {4'b0, pad_spill};
                    end else if (idx_reg == 4'(BLOCK_WORDS - 1)) begin
                        state_next = EMIT;
                        last_next  = 1'b0;
                        extra_next = 1'b0;
                    end
                end
            end
            PAD: begin
                state_next = EMIT;
                // The length only fits if the marker leaves words 14/15 free.
                if (mark_reg <= 5'd13) begin
                    last_next  = 1'b1;
                    extra_next = 1'b0;
                    pend_next  = 1'b0;
                end else begin
                    last_next  = 1'b0;
                    extra_next = 1'b1;
                    pend_next  = (mark_reg == 5'd16);
                end
            end
            EMIT: begin
                if (handshake) begin
                    first_next = 1'b0;
                    idx_next   = '0;
                    if (extra_reg) begin
                        extra_next = 1'b0;
                        pend_next  = 1'b0;
                        last_next  = 1'b1;
                    end else if (last_reg) begin
                        len_next   = '0;
                        first_next = 1'b1;
                        last_next  = 1'b0;
                        state_next = FILL;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            default: state_next = FILL;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word
            localparam bit IS_W0 = (gi == 0);
            logic [WORD_W-1:0] word_reg;
            logic [WORD_W-1:0] len_word;

            if (gi == BLOCK_WORDS - 2) begin : g_len_hi
                assign len_word = len_field[63:32];
            end else if (gi == BLOCK_WORDS - 1) begin : g_len_lo
                assign len_word = len_field[31:0];
            end else begin : g_len_none
                assign len_word = '0;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg <= '0;
                end else begin
                    case (state_reg)
                        FILL: begin
                            if (accept && idx_reg == 4'(gi))
                                word_reg <= wr_word;
                        end
                        PAD: begin
                            if (5'(gi) == mark_reg && spill_reg)
                                word_reg <= {PAD_MARKER, 24'h0};
                            else if (5'(gi) > mark_reg)
                                word_reg <= (mark_reg <= 5'd13) ? len_word : '0;
                        end
                        EMIT: begin
                            // Trailing block: optional pending marker plus the length.
                            if (handshake && extra_reg)
                                word_reg <= (IS_W0 && pend_reg) ? {PAD_MARKER, 24'h0} : len_word;
                        end
                        default: ;
                    endcase
                end
            end

            assign blk_data[BLOCK_W - 1 - WORD_W * gi -: WORD_W] = word_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sha256_padder.sv
// Directed self-checking bench for sha256_padder (big-endian build).
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic [1:0]   in_bytes = '0;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;

    int n_vec = 0;
    int n_bad = 0;
    int tmo_cnt = 0;

    logic [31:0]  w [16];
    logic [511:0] exp_blk;

    sha256_padder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    task automatic clear_w();
        for (int i = 0; i < 16; i++) w[i] = 32'h0;
    endtask

    task automatic pack_w();
        for (int i = 0; i < 16; i++) exp_blk[511 - 32 * i -: 32] = w[i];
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
        int c;
        c = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        while (in_ready !== 1'b1 && c < 64) begin
            @(posedge clk); #1;
            c++;
        end
        if (in_ready !== 1'b1) tmo_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = 2'd0;
    endtask

    task automatic wait_valid();
        int c;
        c = 0;
        while (blk_valid !== 1'b1 && c < 64) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic pop();
        blk_ready = 1'b1;
        @(posedge clk); #1;
        blk_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        n_vec++; if (blk_valid !== 1'b0) begin n_bad++; $display("FAIL rst_blk_valid got %b want 0", blk_valid); end
        n_vec++; if (blk_first !== 1'b0) begin n_bad++; $display("FAIL rst_blk_first got %b want 0", blk_first); end
        n_vec++; if (blk_last !== 1'b0) begin n_bad++; $display("FAIL rst_blk_last got %b want 0", blk_last); end
        n_vec++; if (blk_data !== 512'h0) begin n_bad++; $display("FAIL rst_blk_data got %h want 0", blk_data); end
        rst = 1'b0;
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_release_in_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_rise got %b want 1", in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_abc();
        send_word(32'h61626300, 1'b1, 2'd3);
        n_vec++; if (blk_valid !== 1'b0) begin n_bad++; $display("FAIL abc_pad_cycle got %b want 0", blk_valid); end
        @(posedge clk); #1;
        n_vec++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL abc_latency got %b want 1", blk_valid); end
        clear_w();
        w[0] = 32'h61626380; w[15] = 32'h00000018;
        pack_w();
        n_vec++; if (blk_data !== exp_blk) begin n_bad++; $display("FAIL abc_data got %h want %h", blk_data, exp_blk); end
        n_vec++; if (blk_first !== 1'b1) begin n_bad++; $display("FAIL abc_first got %b want 1", blk_first); end
        n_vec++; if (blk_last !== 1'b1) begin n_bad++; $display("FAIL abc_last got %b want 1", blk_last); end
        pop();
        n_vec++; if (blk_valid !== 1'b0) begin n_bad++; $display("FAIL abc_after_pop got %b want 0", blk_valid); end
        $display("test_abc done");
    endtask

    task automatic test_55_bytes();
        clear_w();
        for (int i = 0; i < 13; i++) begin
            w[i] = 32'h55000000 | i;
            send_word(w[i], 1'b0, 2'd0);
        end
        send_word(32'h41424300, 1'b1, 2'd3);
        w[13] = 32'h41424380; w[15] = 32'h000001B8;
        pack_w();
        wait_valid();
        n_vec++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL b55_valid got %b want 1", blk_valid); end
        n_vec++; if (blk_data !== exp_blk) begin n_bad++; $display("FAIL b55_data got %h want %h", blk_data, exp_blk); end
        n_vec++; if (blk_first !== 1'b1) begin n_bad++; $display("FAIL b55_first got %b want 1", blk_first); end
        n_vec++; if (blk_last !== 1'b1) begin n_bad++; $display("FAIL b55_last got %b want 1", blk_last); end
        pop();
        $display("test_55_bytes done");
    endtask

    task automatic test_56_bytes();
        clear_w();
        for (int i = 0; i < 14; i++) begin
            w[i] = 32'h56000000 | i;
            send_word(w[i], (i == 13), 2'd0);
        end
        w[14] = 32'h80000000;
        pack_w();
        wait_valid();
        n_vec++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL b56_1_valid got %b want 1", blk_valid); end
        n_vec++; if (blk_data !== exp_blk) begin n_bad++; $display("FAIL b56_1_data got %h want %h", blk_data, exp_blk); end
        n_vec++; if (blk_first !== 1'b1) begin n_bad++; $display("FAIL b56_1_first got %b want 1", blk_first); end
        n_vec++; if (blk_last !== 1'b0) begin n_bad++; $display("FAIL b56_1_last got %b want 0", blk_last); end
        pop();
        clear_w();
        w[15] = 32'h000001C0;
        pack_w();
        wait_valid();
        n_vec++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL b56_2_valid got %b want 1", blk_valid); end
        n_vec++; if (blk_data !== exp_blk) begin n_bad++; $display("FAIL b56_2_data got %h want %h", blk_data, exp_blk); end
        n_vec++; if (blk_first !== 1'b0) begin n_bad++; $display("FAIL b56_2_first got %b want 0", blk_first); end
        n_vec++; if (blk_last !== 1'b1) begin n_bad++; $display("FAIL b56_2_last got %b want 1", blk_last); end
        pop();
        $display("test_56_bytes done");
    endtask

    task automatic test_64_bytes();
        clear_w();
        for (int i = 0; i < 16; i++) begin
            w[i] = 32'h64000000 | i;
            send_word(w[i], (i == 15), 2'd0);
        end
        pack_w();
        wait_valid();
        n_vec++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL b64_1_valid got %b want 1", blk_valid); end
        n_vec++; if (blk_data !== exp_blk) begin n_bad++; $display("FAIL b64_1_data got %h want %h", blk_data, exp_blk); end
        n_vec++; if (blk_first !== 1'b1) begin n_bad++; $display("FAIL b64_1_first got %b want 1", blk_first); end
        n_vec++; if (blk_last !== 1'b0) begin n_bad++; $display("FAIL b64_1_last got %b want 0", blk_last); end
        pop();
        clear_w();
        w[0] = 32'h80000000; w[15] = 32'h00000200;
        pack_w();
        wait_valid();
        n_vec++; if (blk_data !== exp_blk) begin n_bad++; $display("FAIL b64_2_data got %h want %h", blk_data, exp_blk); end
        n_vec++; if (blk_first !== 1'b0) begin n_bad++; $display("FAIL b64_2_first got %b want 0", blk_first); end
        n_vec++; if (blk_last !== 1'b1) begin n_bad++; $display("FAIL b64_2_last got %b want 1", blk_last); end
        pop();
        send_word(32'h61626300, 1'b1, 2'd3);
        wait_valid();
        n_vec++; if (blk_first !== 1'b1) begin n_bad++; $display("FAIL b64_next_first got %b want 1", blk_first); end
        n_vec++; if (blk_last !== 1'b1) begin n_bad++; $display("FAIL b64_next_last got %b want 1", blk_last); end
        pop();
        $display("test_64_bytes done");
    endtask

    task automatic test_backpressure();
        clear_w();
        w[0] = 32'h61626380; w[15] = 32'h00000018;
        pack_w();
        send_word(32'h61626300, 1'b1, 2'd3);
        wait_valid();
        in_valid = 1'b1;
        in_data  = 32'h61626300;
        in_last  = 1'b1;
        in_bytes = 2'd3;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_vec++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got %b want 1", k, blk_valid); end
            n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got %b want 0", k, in_ready); end
            n_vec++; if (blk_data !== exp_blk) begin n_bad++; $display("FAIL bp_data[%0d] got %h want %h", k, blk_data, exp_blk); end
            n_vec++; if (blk_first !== 1'b1) begin n_bad++; $display("FAIL bp_first[%0d] got %b want 1", k, blk_first); end
            n_vec++; if (blk_last !== 1'b1) begin n_bad++; $display("FAIL bp_last[%0d] got %b want 1", k, blk_last); end
        end
        pop();
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = 2'd0;
        wait_valid();
        n_vec++; if (blk_data !== exp_blk) begin n_bad++; $display("FAIL bp_held_word_data got %h want %h", blk_data, exp_blk); end
        n_vec++; if (blk_first !== 1'b1) begin n_bad++; $display("FAIL bp_held_word_first got %b want 1", blk_first); end
        pop();
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid_emit();
        for (int i = 0; i < 14; i++) send_word(32'h77000000 | i, (i == 13), 2'd0);
        wait_valid();
        n_vec++; if (blk_valid !== 1'b1) begin n_bad++; $display("FAIL rm_valid_before got %b want 1", blk_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (blk_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid_after got %b want 0", blk_valid); end
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rm_in_ready got %b want 0", in_ready); end
        n_vec++; if (blk_data !== 512'h0) begin n_bad++; $display("FAIL rm_data got %h want 0", blk_data); end
        clear_w();
        w[0] = 32'h61626380; w[15] = 32'h00000018;
        pack_w();
        send_word(32'h61626300, 1'b1, 2'd3);
        wait_valid();
        n_vec++; if (blk_data !== exp_blk) begin n_bad++; $display("FAIL rm_abc_data got %h want %h", blk_data, exp_blk); end
        n_vec++; if (blk_first !== 1'b1) begin n_bad++; $display("FAIL rm_abc_first got %b want 1", blk_first); end
        n_vec++; if (blk_last !== 1'b1) begin n_bad++; $display("FAIL rm_abc_last got %b want 1", blk_last); end
        pop();
        $display("test_reset_mid_emit done");
    endtask

    initial begin
        test_reset();
        test_abc();
        test_55_bytes();
        test_56_bytes();
        test_64_bytes();
        test_backpressure();
        test_reset_mid_emit();
        n_vec++; if (tmo_cnt !== 0) begin n_bad++; $display("FAIL in_ready_timeouts got %0d want 0", tmo_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
